text_banner_render: RTL and testbench

TEXT_BANNER_RENDER -- requirements
Module: text_banner_render

---
 rtl/text_banner_render.sv | 133 +++++++++++++
 tb/tb_text_banner_render.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/text_banner_render.sv
// Text banner renderer: fetches one bitmap row per scan line into a line
// buffer during horizontal blank, then maps screen pixels onto buffer bits
// with optional pixel replication, horizontal scrolling and blinking.
module text_banner_render #(
    parameter int          WIDTH        = 210,
    parameter int          ROWS         = 25,
    parameter int          SCALE_LOG2   = 0,
    parameter int          X0           = 16,
    parameter int          Y0           = 32,
    parameter int          H_LOAD       = 640,
    parameter int          V_TOTAL      = 525,
    parameter int          SCROLL_STEP  = 1,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [7:0]  FG           = 8'hFF,
    parameter logic [7:0]  BG           = 8'h00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       pixel_x,
    input  logic [9:0]       pixel_y,
    input  logic             video_on,
    input  logic             frame_tick,
    input  logic             scroll_en,
    input  logic             blink_en,
    output logic [7:0]       rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    output logic             text_on,
    output logic [7:0]       rgb
);

    localparam int OW = $clog2(WIDTH);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // All coordinate arithmetic is done at 16 bits so that the window end
    // (up to X0 + 4*WIDTH) and the unwrapped column sum never overflow.
    localparam logic [15:0] X0_W     = 16'(X0);
    localparam logic [15:0] Y0_W     = 16'(Y0);
    localparam logic [15:0] XEND_W   = 16'(X0 + (WIDTH << SCALE_LOG2));
    localparam logic [15:0] YEND_W   = 16'(Y0 + (ROWS << SCALE_LOG2));
    localparam logic [15:0] HLOAD_W  = 16'(H_LOAD);
    localparam logic [15:0] HLOAD1_W = 16'(H_LOAD + 1);
    localparam logic [15:0] VLAST_W  = 16'(V_TOTAL - 1);
    localparam logic [15:0] WIDTH_W  = 16'(WIDTH);
    localparam logic [15:0] WLAST_W  = 16'(WIDTH - 1);
    localparam logic [15:0] STEP_W   = 16'(SCROLL_STEP);
    localparam logic [FW-1:0] FLAST  = FW'(BLINK_FRAMES - 1);

    logic [WIDTH-1:0] linebuf;
    logic             line_valid;
    logic [OW-1:0]    offset;
    logic [FW-1:0]    frame_cnt;
    logic             blink_phase;

    logic [15:0] px, py, ny, ny_rel, row;
    logic [15:0] col_rel, col_sum, col, bidx_full, off_sum, off_next;
    logic [OW-1:0] bidx;
    logic fetch, load, ny_ok, in_win, lit_next;

    // Line-fetch geometry, column mapping and the next-cycle pixel decision.
    always_comb begin
        px        = {6'd0, pixel_x};
        py        = {6'd0, pixel_y};
        fetch     = (px == HLOAD_W);
        load      = (px == HLOAD1_W);
        ny        = (py == VLAST_W) ? 16'd0 : py + 16'd1;
        ny_rel    = ny - Y0_W;
        row       = ny_rel >> SCALE_LOG2;
        ny_ok     = (ny >= Y0_W) && (ny < YEND_W);
        col_rel   = (px - X0_W) >> SCALE_LOG2;
        col_sum   = col_rel + {{(16-OW){1'b0}}, offset};
        col       = (col_sum >= WIDTH_W) ? col_sum - WIDTH_W : col_sum;
        bidx_full = WLAST_W - col;
        bidx      = bidx_full[OW-1:0];
        in_win    = video_on && line_valid && (px >= X0_W) && (px < XEND_W);
        lit_next  = in_win && linebuf[bidx] && !(blink_en && blink_phase);
        off_sum   = {{(16-OW){1'b0}}, offset} + STEP_W;
        off_next  = (off_sum >= WIDTH_W) ? off_sum - WIDTH_W : off_sum;
    end

    // Row fetch at H_LOAD, buffer capture one cycle later; both hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr   <= '0;
            line_valid <= 1'b0;
            linebuf    <= '0;
        end else begin
            if (fetch) begin
                rom_addr   <= row[7:0];
                line_valid <= ny_ok;
            end
            if (load) begin
                linebuf <= rom_data;
            end
        end
    end

    // Per-frame scroll offset and blink frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            offset      <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_tick) begin
            if (scroll_en) begin
                offset <= off_next[OW-1:0];
            end
            if (frame_cnt == FLAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Registered pixel outputs, one cycle behind the pixel coordinates.
    always_ff @(posedge clk) begin
        if (reset) begin
            text_on <= 1'b0;
            rgb     <= 8'h00;
        end else begin
            text_on <= lit_next;
            if (lit_next) begin
                rgb <= FG;
            end else if (video_on) begin
                rgb <= BG;
            end else begin
                rgb <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_text_banner_render.sv
// Directed bench for text_banner_render: default instance plus a 2x-scaled
// instance, both fed from a combinational ROM model.
module tb_text_banner_render;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on, frame_tick, scroll_en, blink_en;
    logic [7:0]  rom_addr1, rom_addr2, rgb1, rgb2;
    logic [209:0] rom_data1, rom_data2;
    logic        text_on1, text_on2;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    text_banner_render u_dut (
        .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .frame_tick(frame_tick), .scroll_en(scroll_en),
        .blink_en(blink_en), .rom_addr(rom_addr1), .rom_data(rom_data1),
        .text_on(text_on1), .rgb(rgb1)
    );

    text_banner_render #(.SCALE_LOG2(1)) u_dut2 (
        .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .frame_tick(frame_tick), .scroll_en(scroll_en),
        .blink_en(blink_en), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .text_on(text_on2), .rgb(rgb2)
    );

    // Bitmap content: row 8 is a hand-checkable pattern (column c lit when
    // c mod 3 == 1); other rows use a hash so that any shift is visible.
    function automatic bit col_lit(input int r, input int c);
        int unsigned h;
        if (r == 8) return (c % 3) == 1;
        h = 32'(c) * 32'd2654435761 + 32'(r) * 32'd97;
        return h[16];
    endfunction

    function automatic logic [209:0] row_bits(input logic [7:0] a);
        logic [209:0] v;
        for (int c = 0; c < 210; c++) v[209-c] = col_lit(int'(a), c);
        return v;
    endfunction

    assign rom_data1 = row_bits(rom_addr1);
    assign rom_data2 = row_bits(rom_addr2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d)", name, act, exp, pixel_x, pixel_y);
        end
    endtask

    task automatic fetch(input int y);
        pixel_y  = 10'(y);
        video_on = 1'b0;
        pixel_x  = 10'd640;
        tick();
        pixel_x  = 10'd641;
        tick();
    endtask

    task automatic frame_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            pixel_x    = 10'd700;
            video_on   = 1'b0;
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Active portion of one line on the default instance.
    task automatic scan(input int y, input int row, input int off, input bit valid, input bit blank);
        bit exp_on;
        for (int x = 0; x < 640; x++) begin
            pixel_x  = 10'(x);
            pixel_y  = 10'(y);
            video_on = 1'b1;
            tick();
            exp_on = valid && !blank && x >= 16 && x < 226 && col_lit(row, (x - 16 + off) % 210);
            check("text_on", 32'(text_on1), 32'(exp_on));
            check("rgb", 32'(rgb1), exp_on ? 32'hFF : 32'h00);
        end
    endtask

    // Active portion of one line on the 2x instance.
    task automatic scan2(input int y, input int row, input bit valid);
        bit exp_on;
        for (int x = 0; x < 640; x++) begin
            pixel_x  = 10'(x);
            pixel_y  = 10'(y);
            video_on = 1'b1;
            tick();
            exp_on = valid && x >= 16 && x < 436 && col_lit(row, (x - 16) >> 1);
            check("x2_text_on", 32'(text_on2), 32'(exp_on));
        end
    endtask

    typedef struct {
        int         x;
        bit         vo;
        bit         exp_on;
        logic [7:0] exp_rgb;
    } vec_t;

    vec_t vt[12];

    initial begin
        // Line y=40 holding row 8, offset 0, no blink.
        vt[0]  = '{15,  1'b1, 1'b0, 8'h00};
        vt[1]  = '{16,  1'b1, 1'b0, 8'h00};
        vt[2]  = '{17,  1'b1, 1'b1, 8'hFF};
        vt[3]  = '{18,  1'b1, 1'b0, 8'h00};
        vt[4]  = '{19,  1'b1, 1'b0, 8'h00};
        vt[5]  = '{20,  1'b1, 1'b1, 8'hFF};
        vt[6]  = '{23,  1'b1, 1'b1, 8'hFF};
        vt[7]  = '{224, 1'b1, 1'b1, 8'hFF};
        vt[8]  = '{225, 1'b1, 1'b0, 8'h00};
        vt[9]  = '{226, 1'b1, 1'b0, 8'h00};
        vt[10] = '{17,  1'b0, 1'b0, 8'h00};
        vt[11] = '{300, 1'b1, 1'b0, 8'h00};

        reset = 1'b1; pixel_x = '0; pixel_y = '0; video_on = 1'b0;
        frame_tick = 1'b0; scroll_en = 1'b0; blink_en = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_rom_addr", 32'(rom_addr1), 32'd0);
        check("rst_text_on", 32'(text_on1), 32'd0);
        check("rst_rgb", 32'(rgb1), 32'd0);
        check("rst_rom_addr_x2", 32'(rom_addr2), 32'd0);

        // Row 8 on line 40, checked against the table and a full sweep.
        fetch(39);
        check("fetch_rom_addr", 32'(rom_addr1), 32'd8);
        check("fetch_rom_addr_x2", 32'(rom_addr2), 32'd4);
        for (int i = 0; i < 12; i++) begin
            pixel_x  = 10'(vt[i].x);
            pixel_y  = 10'd40;
            video_on = vt[i].vo;
            tick();
            check("vec_text_on", 32'(text_on1), 32'(vt[i].exp_on));
            check("vec_rgb", 32'(rgb1), 32'(vt[i].exp_rgb));
        end
        scan(40, 8, 0, 1'b1, 1'b0);
        scan2(40, 4, 1'b1);

        // Bottom edge of the 2x window.
        fetch(80);
        check("x2_last_row_addr", 32'(rom_addr2), 32'd24);
        scan2(81, 24, 1'b1);
        fetch(81);
        scan2(82, 0, 1'b0);

        // Wrap of the line counter: line 0 is never part of the banner.
        fetch(524);
        scan(0, 0, 0, 1'b0, 1'b0);

        // Scroll up to the last offset, then wrap.
        do_reset();
        scroll_en = 1'b1;
        frame_ticks(209);
        fetch(40);
        check("row9_addr", 32'(rom_addr1), 32'd9);
        scan(41, 9, 209, 1'b1, 1'b0);
        frame_ticks(1);
        scan(41, 9, 0, 1'b1, 1'b0);

        // Frame tick landing on the fetch cycle: both take effect.
        pixel_x = 10'd640; pixel_y = 10'd40; video_on = 1'b0; frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0; pixel_x = 10'd641;
        tick();
        check("coinc_rom_addr", 32'(rom_addr1), 32'd9);
        scan(41, 9, 1, 1'b1, 1'b0);

        // Offset holds with scrolling disabled.
        scroll_en = 1'b0;
        frame_ticks(3);
        scan(41, 9, 1, 1'b1, 1'b0);

        // Reset mid-line: blank from the next cycle until the next fetch.
        for (int x = 0; x < 100; x++) begin
            pixel_x = 10'(x); pixel_y = 10'd41; video_on = 1'b1;
            tick();
            check("pre_rst_text_on", 32'(text_on1),
                  32'(x >= 16 && col_lit(9, (x - 16 + 1) % 210)));
        end
        pixel_x = 10'd100; reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_text_on", 32'(text_on1), 32'd0);
        check("midrst_rgb", 32'(rgb1), 32'd0);
        check("midrst_rom_addr", 32'(rom_addr1), 32'd0);
        for (int x = 101; x < 640; x++) begin
            pixel_x = 10'(x); video_on = 1'b1;
            tick();
            check("post_rst_text_on", 32'(text_on1), 32'd0);
        end
        fetch(41);
        check("post_rst_addr", 32'(rom_addr1), 32'd10);
        scan(42, 10, 0, 1'b1, 1'b0);

        // Blink: visible for frames 0..29, blank 30..59, visible from 60.
        do_reset();
        blink_en = 1'b1;
        fetch(40);
        frame_ticks(29);
        scan(41, 9, 0, 1'b1, 1'b0);
        frame_ticks(1);
        scan(41, 9, 0, 1'b1, 1'b1);
        frame_ticks(29);
        scan(41, 9, 0, 1'b1, 1'b1);
        frame_ticks(1);
        scan(41, 9, 0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
